// File: rtl/vend_pkg.sv
// Shared types for the vending dispense scheduler: FSM states, change codes
// and the code-to-coin-count mapping.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MOTOR,
    WAIT_DROP,
    CHANGE,
    FINISH
  } state_t;

  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;

  // Code 11 is not a valid request; it pays out as Rs 10.
  function automatic logic [1:0] chg_to_coins(input logic [1:0] code);
    case (code)
      CHG_NONE:      return 2'd0;
      CHG_5:         return 2'd1;
      CHG_10, 2'b11: return 2'd2;
      default:       return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first asserted request at or after ptr, as one-hot
// grant and binary index.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] pos;
  logic             found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    pos   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      pos = IDX_W'((int'(ptr) + k) % NREQ);
      if (!found && req[pos]) begin
        gnt[pos] = 1'b1;
        idx      = pos;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vend_dispense_sched.sv
// Shares one dispense motor and one Rs 5 change hopper among NREQ front-ends,
// serving one latched request at a time in round-robin order.
module vend_dispense_sched
  import vend_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int MOTOR_CYCLES = 8,
  parameter int DROP_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] chg,
  input  logic              drop_sense,
  output logic [NREQ-1:0]   grant,
  output logic              motor_on,
  output logic              hopper_pulse,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   fault,
  output logic              busy
);

  localparam int IDX_W   = $clog2(NREQ);
  localparam int CNT_MAX = (MOTOR_CYCLES > DROP_TIMEOUT) ? MOTOR_CYCLES : DROP_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       coins, coins_n;
  logic             phase, phase_n;
  logic [IDX_W-1:0] owner, owner_n, owner_inc;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_n;
  logic [NREQ-1:0]  arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic [1:0]       grant_code;

  logic [NREQ-1:0]  grant_n, done_n, fault_n;
  logic             motor_n, hopper_n, busy_n;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    grant_code = '0;
    for (int i = 0; i < NREQ; i++)
      if (arb_gnt[i]) grant_code = chg[2*i +: 2];
  end

  assign owner_inc = (owner == IDX_W'(NREQ - 1)) ? '0 : owner + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      coins        <= '0;
      phase        <= 1'b0;
      owner        <= '0;
      rr_ptr       <= '0;
      grant        <= '0;
      motor_on     <= 1'b0;
      hopper_pulse <= 1'b0;
      done         <= '0;
      fault        <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      coins        <= coins_n;
      phase        <= phase_n;
      owner        <= owner_n;
      rr_ptr       <= rr_ptr_n;
      grant        <= grant_n;
      motor_on     <= motor_n;
      hopper_pulse <= hopper_n;
      done         <= done_n;
      fault        <= fault_n;
      busy         <= busy_n;
    end
  end

  // WAIT_DROP with cnt==0 is the timeout cycle: fault shows then, grant drops next.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    coins_n  = coins;
    phase_n  = phase;
    owner_n  = owner;
    rr_ptr_n = rr_ptr;
    case (state)
      IDLE: begin
        if (|req) begin
          state_n = MOTOR;
          owner_n = arb_idx;
          coins_n = chg_to_coins(grant_code);
          cnt_n   = CNT_W'(MOTOR_CYCLES);
          phase_n = 1'b0;
        end
      end
      MOTOR: begin
        if (cnt == CNT_W'(1)) begin
          state_n = WAIT_DROP;
          cnt_n   = CNT_W'(DROP_TIMEOUT);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      WAIT_DROP: begin
        if (cnt == '0) begin
          state_n  = IDLE;
          rr_ptr_n = owner_inc;
        end else if (drop_sense) begin
          state_n = CHANGE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      CHANGE: begin
        // phase 0 is the pulse cycle, phase 1 the low gap that retires a coin.
        if (coins == 2'd0) begin
          state_n = FINISH;
        end else if (!phase) begin
          phase_n = 1'b1;
        end else begin
          phase_n = 1'b0;
          coins_n = coins - 2'd1;
          if (coins == 2'd1) state_n = FINISH;
        end
      end
      FINISH: begin
        state_n  = IDLE;
        rr_ptr_n = owner_inc;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    grant_n = '0;
    if (state_n != IDLE) grant_n = (state == IDLE) ? arb_gnt : grant;
    motor_n  = (state_n == MOTOR);
    hopper_n = (state_n == CHANGE) && (coins_n != 2'd0) && !phase_n;
    done_n   = (state_n == FINISH) ? grant_n : '0;
    fault_n  = ((state_n == WAIT_DROP) && (cnt_n == '0)) ? grant_n : '0;
    busy_n   = (state_n != IDLE);
  end

endmodule

// File: tb/tb_vend_dispense_sched.sv
// Bench for vend_dispense_sched: directed table rows, reset corner sequences
// and random scenarios against a service-level timeline model.
module tb_vend_dispense_sched;

  localparam int NREQ = 4;
  localparam int MC   = 8;
  localparam int DT   = 64;
  localparam int MAXL = 512;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  chg;
  logic        drop_sense;
  logic [3:0]  grant, done, fault;
  logic        motor_on, hopper_pulse, busy;
  logic [14:0] dut_out;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;

  // Expected per-cycle timeline; out = {grant, motor, hop, done, fault, busy}.
  logic [3:0]  x_req [MAXL];
  logic [7:0]  x_chg [MAXL];
  logic        x_drop[MAXL];
  logic        x_wd  [MAXL];
  logic [14:0] x_out [MAXL];

  typedef struct {
    logic [3:0]  mask;
    logic [7:0]  codes;
    logic [31:0] dly;
    int          exp_end;
    int          exp_hops;
    int          exp_motor;
    logic [3:0]  exp_done;
    logic [3:0]  exp_fault;
    logic [7:0]  exp_ord;
    int          exp_n;
  } row_t;

  row_t tbl[6];

  vend_dispense_sched #(.NREQ(NREQ), .MOTOR_CYCLES(MC), .DROP_TIMEOUT(DT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .chg          (chg),
    .drop_sense   (drop_sense),
    .grant        (grant),
    .motor_on     (motor_on),
    .hopper_pulse (hopper_pulse),
    .done         (done),
    .fault        (fault),
    .busy         (busy)
  );

  assign dut_out = {grant, motor_on, hopper_pulse, done, fault, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] ov(input logic [3:0] g, input logic mo, input logic hp,
                                     input logic [3:0] dn, input logic [3:0] ft, input logic bz);
    return {g, mo, hp, dn, ft, bz};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample mid-cycle, advance past next edge.
  task automatic apply(input logic [3:0] r, input logic [7:0] c, input logic dr, input logic rs,
                       input logic [14:0] exp, input string nm, output logic [14:0] got);
    req = r; chg = c; drop_sense = dr; rst = rs;
    @(negedge clk);
    got = dut_out;
    check(nm, 32'(got), 32'(exp));
    @(posedge clk); #1;
  endtask

  task automatic run_scn(input int sid, input logic [3:0] mask, input logic [7:0] codes,
                         input logic [31:0] dly, output int o_end, output int o_hops,
                         output int o_motor, output logic [3:0] o_done, output logic [3:0] o_fault,
                         output logic [7:0] o_ord, output int o_n);
    int t, e, m, d, o, p, cd, coins, dl, len;
    int st[4];
    int rl[4];
    logic [3:0]  pend, prev_g;
    logic [14:0] got;
    for (int k = 0; k < MAXL; k++) begin
      x_req[k] = '0; x_chg[k] = '0; x_drop[k] = 1'b0; x_wd[k] = 1'b0; x_out[k] = '0;
    end
    for (int j = 0; j < 4; j++) begin st[j] = -1; rl[j] = -1; end
    pend = mask; t = 0; p = m_ptr;
    while (pend != 0) begin
      o = -1;
      for (int j = 0; j < NREQ; j++)
        if (o < 0 && pend[(p + j) % NREQ]) o = (p + j) % NREQ;
      cd    = int'((codes >> (2 * o)) & 8'h3);
      coins = (cd == 0) ? 0 : (cd == 1) ? 1 : 2;
      dl    = int'((dly >> (8 * o)) & 32'hFF);
      m     = t + MC;
      if (dl <= DT) begin
        d = m + dl;
        e = (coins == 0) ? d + 2 : d + 1 + 2 * coins;
        x_drop[d] = 1'b1;
        for (int k = m + 1; k <= d; k++) x_wd[k] = 1'b1;
        for (int c = 0; c < coins; c++) x_out[d + 1 + 2 * c][9] = 1'b1;
        x_out[e][5 + o] = 1'b1;
      end else begin
        e = m + DT + 1;
        for (int k = m + 1; k <= e; k++) x_wd[k] = 1'b1;
        x_out[e][1 + o] = 1'b1;
      end
      for (int k = t + 1; k <= e; k++) begin x_out[k][11 + o] = 1'b1; x_out[k][0] = 1'b1; end
      for (int k = t + 1; k <= m; k++) x_out[k][10] = 1'b1;
      st[o] = t;
      rl[o] = t + int'($urandom_range(0, e - t));
      pend[o] = 1'b0;
      p = (o + 1) % NREQ;
      t = e + 1;
    end
    m_ptr = p;
    len = t + 2;
    for (int k = 0; k < len; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        x_req[k][j] = mask[j] && (k <= rl[j]);
        x_chg[k][2 * j +: 2] = (mask[j] && k <= st[j]) ? codes[2 * j +: 2] : 2'($urandom_range(0, 3));
      end
      if (!x_wd[k] && $urandom_range(0, 3) == 0) x_drop[k] = 1'b1;
    end
    o_end = -1; o_hops = 0; o_motor = 0; o_done = '0; o_fault = '0; o_ord = '0; o_n = 0;
    prev_g = '0;
    for (int k = 0; k < len; k++) begin
      apply(x_req[k], x_chg[k], x_drop[k], 1'b0, x_out[k], $sformatf("scn%0d_cyc%0d", sid, k), got);
      if (got[14:11] != 0 && got[14:11] != prev_g) begin
        for (int j = 0; j < NREQ; j++)
          if (got[11 + j] && o_n < 4) o_ord[2 * o_n +: 2] = 2'(j);
        o_n++;
      end
      prev_g = got[14:11];
      if (got[10]) o_motor++;
      if (got[9]) o_hops++;
      o_done  |= got[8:5];
      o_fault |= got[4:1];
      if (got[8:5] != 0 || got[4:1] != 0) o_end = k;
    end
  endtask

  initial begin
    logic [14:0] got;
    int r_end, r_hops, r_motor, r_n;
    logic [3:0] r_done, r_fault;
    logic [7:0] r_ord;

    tbl[0] = '{4'b0001, 8'b00000001, 32'h00000003, 14,  1, 8,  4'b0001, 4'b0000, 8'h00, 1};
    tbl[1] = '{4'b1000, 8'b11000000, 32'h02000000, 15,  2, 8,  4'b1000, 4'b0000, 8'h03, 1};
    tbl[2] = '{4'b1111, 8'b10101010, 32'h01010101, 59,  8, 32, 4'b1111, 4'b0000, 8'hE4, 4};
    tbl[3] = '{4'b0011, 8'b00000010, 32'h00000563, 89,  0, 16, 4'b0010, 4'b0001, 8'h04, 2};
    tbl[4] = '{4'b0101, 8'b00000001, 32'h00010040, 87,  1, 16, 4'b0101, 4'b0000, 8'h02, 2};
    tbl[5] = '{4'b1110, 8'b00100100, 32'h40014100, 163, 2, 24, 4'b1100, 4'b0010, 8'h39, 3};

    rst = 1'b1; req = '0; chg = '0; drop_sense = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    apply(4'b0000, 8'h00, 1'b1, 1'b1, '0, "reset_hold", got);
    apply(4'b0000, 8'h00, 1'b0, 1'b0, '0, "reset_state", got);
    m_ptr = 0;

    for (int i = 0; i < 6; i++) begin
      run_scn(i, tbl[i].mask, tbl[i].codes, tbl[i].dly, r_end, r_hops, r_motor, r_done, r_fault, r_ord, r_n);
      check($sformatf("row%0d_end", i),   32'(r_end),   32'(tbl[i].exp_end));
      check($sformatf("row%0d_hops", i),  32'(r_hops),  32'(tbl[i].exp_hops));
      check($sformatf("row%0d_motor", i), 32'(r_motor), 32'(tbl[i].exp_motor));
      check($sformatf("row%0d_done", i),  32'(r_done),  32'(tbl[i].exp_done));
      check($sformatf("row%0d_fault", i), 32'(r_fault), 32'(tbl[i].exp_fault));
      check($sformatf("row%0d_order", i), 32'(r_ord),   32'(tbl[i].exp_ord));
      check($sformatf("row%0d_nsvc", i),  32'(r_n),     32'(tbl[i].exp_n));
    end

    // Leave rr_ptr at 2, then abort a service mid-motor.
    run_scn(10, 4'b0010, 8'h08, 32'h00000100, r_end, r_hops, r_motor, r_done, r_fault, r_ord, r_n);
    apply(4'b0100, 8'h00, 1'b0, 1'b0, '0, "rstm_idle", got);
    apply(4'b0100, 8'h00, 1'b0, 1'b0, ov(4'b0100, 1, 0, 0, 0, 1), "rstm_motor1", got);
    apply(4'b0100, 8'h00, 1'b1, 1'b0, ov(4'b0100, 1, 0, 0, 0, 1), "rstm_motor2", got);
    apply(4'b0100, 8'h00, 1'b0, 1'b1, ov(4'b0100, 1, 0, 0, 0, 1), "rstm_motor3", got);
    apply(4'b0000, 8'h00, 1'b0, 1'b0, '0, "rstm_after", got);
    for (int i = 0; i < 75; i++)
      apply(4'b0000, 8'h00, 1'b0, 1'b0, '0, $sformatf("rstm_quiet%0d", i), got);
    apply(4'b1111, 8'h00, 1'b0, 1'b0, '0, "rstm_req_idle", got);
    apply(4'b1111, 8'h00, 1'b0, 1'b1, ov(4'b0001, 1, 0, 0, 0, 1), "rstm_ptr0", got);
    apply(4'b0000, 8'h00, 1'b0, 1'b0, '0, "rstm_clean", got);

    // Abort during the first change pulse; req released while in WAIT_DROP.
    apply(4'b0010, 8'h08, 1'b0, 1'b0, '0, "rstc_idle", got);
    for (int i = 1; i <= 8; i++)
      apply(4'b0010, 8'h08, 1'b0, 1'b0, ov(4'b0010, 1, 0, 0, 0, 1), $sformatf("rstc_motor%0d", i), got);
    apply(4'b0000, 8'h08, 1'b1, 1'b0, ov(4'b0010, 0, 0, 0, 0, 1), "rstc_drop", got);
    apply(4'b0000, 8'h00, 1'b0, 1'b1, ov(4'b0010, 0, 1, 0, 0, 1), "rstc_pulse", got);
    for (int i = 0; i < 8; i++)
      apply(4'b0000, 8'h00, 1'b0, 1'b0, '0, $sformatf("rstc_quiet%0d", i), got);
    m_ptr = 0;

    for (int i = 0; i < 25; i++) begin
      logic [31:0] dl;
      for (int j = 0; j < 4; j++) dl[8 * j +: 8] = 8'($urandom_range(1, 72));
      run_scn(100 + i, 4'($urandom_range(1, 15)), 8'($urandom), dl,
              r_end, r_hops, r_motor, r_done, r_fault, r_ord, r_n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
